// File: rtl/clock_display_pkg.sv
// clock_display_pkg: segment codes, blink field codes and digit count shared by the display path
package clock_display_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [5:0] AN_OFF   = 6'h3F;
  typedef enum logic [1:0] {
    BLINK_NONE = 2'b00,
    BLINK_HR   = 2'b01,
    BLINK_MIN  = 2'b10,
    BLINK_SEC  = 2'b11
  } blink_sel_e;
  function automatic logic [5:0] blink_mask(input logic [1:0] sel);
    return sel == BLINK_HR  ? 6'b110000 :
           sel == BLINK_MIN ? 6'b001100 :
           sel == BLINK_SEC ? 6'b000011 : 6'b000000;
  endfunction
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: BCD digit to active-low {g,f,e,d,c,b,a} segments, dash for codes above 9
module bcd_to_7seg
  import clock_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexes a frame-snapshotted HH:MM:SS onto a 6-digit common-anode display
// ports: clk, reset_n (async low), enable, six BCD digits, blink_sel -> an[5:0], seg[6:0], dp (all active-low)
module bcd_display_scanner
  import clock_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] ms_hr,
  input  logic [3:0] ls_hr,
  input  logic [3:0] ms_min,
  input  logic [3:0] ls_min,
  input  logic [3:0] ms_sec,
  input  logic [3:0] ls_sec,
  input  logic [1:0] blink_sel,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [DW-1:0] r_div;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic          r_snap_pending;
  logic [3:0]    r_snap [NUM_DIGITS];
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          w_slot_end;
  logic          w_wrap;
  logic [3:0]    w_digit;
  logic [5:0]    w_sel;
  logic          w_dark;
  logic [6:0]    w_seg;
  assign w_slot_end = r_div == DW'(REFRESH_DIV - 1);
  assign w_wrap     = w_slot_end && r_idx == 3'd5;
  assign w_sel      = 6'b1 << r_idx;
  assign w_digit    = r_idx == 3'd5 ? r_snap[5] :
                      r_idx == 3'd4 ? r_snap[4] :
                      r_idx == 3'd3 ? r_snap[3] :
                      r_idx == 3'd2 ? r_snap[2] :
                      r_idx == 3'd1 ? r_snap[1] : r_snap[0];
  // dark covers disabled scanning, blink-phase blanking and leading-zero hours
  assign w_dark = !enable
               || (r_blink_phase && |(blink_mask(blink_sel) & w_sel))
               || (LZ_BLANK && r_idx == 3'd5 && r_snap[5] == 4'd0);
  bcd_to_7seg u_dec (
    .i_bcd(w_digit),
    .o_seg(w_seg)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_div          <= '0;
      r_idx          <= '0;
      r_frame_cnt    <= '0;
      r_blink_phase  <= 1'b0;
      r_snap_pending <= 1'b1;
      r_snap         <= '{default: 4'd0};
    end else if (enable) begin
      r_div <= w_slot_end ? '0 : r_div + 1'b1;
      if (w_slot_end)
        r_idx <= r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1;
      if (w_wrap) begin
        r_frame_cnt   <= r_frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : r_frame_cnt + 1'b1;
        r_blink_phase <= r_blink_phase ^ (r_frame_cnt == FW'(BLINK_FRAMES - 1));
      end
      // snapshot at frame start keeps a frame tear-free
      if (r_snap_pending || w_wrap) begin
        r_snap_pending <= 1'b0;
        r_snap[0]      <= ls_sec;
        r_snap[1]      <= ms_sec;
        r_snap[2]      <= ls_min;
        r_snap[3]      <= ms_min;
        r_snap[4]      <= ls_hr;
        r_snap[5]      <= ms_hr;
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_dark ? AN_OFF : ~w_sel;
      r_seg <= w_dark ? SEG_OFF : w_seg;
      r_dp  <= w_dark || !(r_idx == 3'd2 || r_idx == 3'd4);
    end
  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: scoreboard plus decode vector table and hand-written scan sequences
module tb_bcd_display_scanner;
  logic clk = 1'b0, reset_n = 1'b1, enable = 1'b0;
  logic [3:0] ms_hr = 0, ls_hr = 0, ms_min = 0, ls_min = 0, ms_sec = 0, ls_sec = 0;
  logic [1:0] blink_sel = 2'b00;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  bcd_display_scanner #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ms_hr(ms_hr), .ls_hr(ls_hr), .ms_min(ms_min), .ls_min(ls_min),
    .ms_sec(ms_sec), .ls_sec(ls_sec), .blink_sel(blink_sel),
    .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [5:0] an; logic [6:0] seg; logic dp;} out_t;
  typedef struct {logic [3:0] code; logic [6:0] seg;} vec_t;
  localparam out_t DARK = {6'h3F, 7'h7F, 1'b1};
  out_t q[$];
  vec_t vt[16];
  logic [6:0] segt [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  int errors = 0, checks = 0;
  int m_div, m_idx, m_frame, cur_idx;
  bit m_phase, m_pend;
  logic [3:0] m_snap [6];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void m_reset();
    m_div = 0; m_idx = 0; m_frame = 0; m_phase = 0; m_pend = 1; cur_idx = -1;
    for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
  endfunction
  function automatic out_t m_out();
    logic [5:0] msk;
    bit blank;
    msk = blink_sel == 2'd1 ? 6'b110000 : blink_sel == 2'd2 ? 6'b001100 :
          blink_sel == 2'd3 ? 6'b000011 : 6'b000000;
    blank = (m_phase && msk[m_idx]) || (m_idx == 5 && m_snap[5] == 4'd0);
    if (!enable || blank) return DARK;
    return {6'h3F & ~(6'b1 << m_idx), segt[m_snap[m_idx]], !(m_idx == 2 || m_idx == 4)};
  endfunction
  function automatic void m_step();
    if (!enable) return;
    if (m_pend || (m_idx == 5 && m_div == 3)) begin
      m_snap = '{ls_sec, ms_sec, ls_min, ms_min, ls_hr, ms_hr};
      m_pend = 0;
    end
    if (m_div < 3) m_div++;
    else begin
      m_div = 0;
      if (m_idx < 5) m_idx++;
      else begin
        m_idx = 0;
        if (m_frame == 1) begin m_frame = 0; m_phase = !m_phase; end
        else m_frame++;
      end
    end
  endfunction
  task automatic tick();
    out_t e;
    int pi;
    e = m_out();
    pi = enable ? m_idx : -1;
    q.push_back(e);
    m_step();
    @(posedge clk); #1;
    e = q.pop_front();
    chk("scoreboard", int'({an, seg, dp}), int'(e));
    cur_idx = pi;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    q.delete();
    m_reset();
    chk("reset_async", int'({an, seg, dp}), int'(DARK));
    @(posedge clk); #1;
    chk("reset_hold", int'({an, seg, dp}), int'(DARK));
    reset_n = 1'b1;
  endtask
  task automatic goto_slot(input int idx);
    int n = 0;
    do begin tick(); n++; end while (cur_idx != idx && n < 60);
    if (cur_idx != idx) chk("goto_slot_timeout", cur_idx, idx);
  endtask
  task automatic goto_wrap();
    int n = 0;
    while (!(m_idx == 5 && m_div == 3) && n < 60) begin tick(); n++; end
    if (!(m_idx == 5 && m_div == 3)) chk("wrap_timeout", m_idx, 5);
  endtask
  task automatic set_time(input logic [23:0] t);
    {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec} = t;
  endtask
  initial begin
    int ecnt, lcnt, dcnt, n;
    logic [5:0] an_seq [6];
    an_seq = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    vt[0]  = '{4'h0, 7'h40}; vt[1]  = '{4'h1, 7'h79}; vt[2]  = '{4'h2, 7'h24}; vt[3]  = '{4'h3, 7'h30};
    vt[4]  = '{4'h4, 7'h19}; vt[5]  = '{4'h5, 7'h12}; vt[6]  = '{4'h6, 7'h02}; vt[7]  = '{4'h7, 7'h78};
    vt[8]  = '{4'h8, 7'h00}; vt[9]  = '{4'h9, 7'h10}; vt[10] = '{4'hA, 7'h3F}; vt[11] = '{4'hB, 7'h3F};
    vt[12] = '{4'hC, 7'h3F}; vt[13] = '{4'hD, 7'h3F}; vt[14] = '{4'hE, 7'h3F}; vt[15] = '{4'hF, 7'h3F};
    m_reset();
    #2;
    set_time(24'h235958);
    enable = 1'b1;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      tick();
      chk("an_sequence", an, an_seq[k / 4]);
      if (k >= 1 && k <= 3) chk("first_digit_8", seg, 7'h00);
    end
    for (int i = 0; i < 16; i++) begin
      ls_sec = vt[i].code;
      goto_wrap();
      tick();
      tick();
      chk("decode_an", an, 6'h3E);
      chk("decode_seg", seg, vt[i].seg);
    end
    set_time(24'h123456);
    goto_wrap();
    tick();
    goto_slot(2);
    set_time(24'h070000);
    goto_slot(3); chk("tear_free_d3", seg, 7'h30);
    goto_slot(4); chk("tear_free_d4", seg, 7'h24);
    goto_slot(5); chk("tear_free_d5", seg, 7'h79);
    goto_slot(0); chk("new_frame_d0", seg, 7'h40);
    goto_slot(4); chk("new_frame_d4", seg, 7'h78);
    goto_slot(5); chk("lz_blank_an", an, 6'h3F); chk("lz_blank_seg", seg, 7'h7F);
    set_time(24'h123456);
    goto_wrap();
    tick();
    for (int k = 0; k < 24; k++) begin
      tick();
      chk("colon", dp, !(an == 6'h3B || an == 6'h2F));
    end
    blink_sel = 2'b10;
    do_reset();
    ecnt = 0; lcnt = 0; dcnt = 0;
    for (int k = 0; k < 96; k++) begin
      tick();
      if (an == 6'h3B || an == 6'h37) begin if (k < 48) ecnt++; else lcnt++; end
      if (k >= 48 && an == 6'h3F) dcnt++;
    end
    chk("blink_shown", ecnt, 16);
    chk("blink_hidden", lcnt, 0);
    chk("blink_dark_cycles", dcnt, 16);
    ecnt = 0;
    for (int k = 0; k < 48; k++) begin tick(); if (an == 6'h3B || an == 6'h37) ecnt++; end
    chk("blink_shown_again", ecnt, 16);
    blink_sel = 2'b00;
    dcnt = 0;
    for (int k = 0; k < 48; k++) begin tick(); if (an == 6'h3F) dcnt++; end
    chk("blink_none", dcnt, 0);
    goto_slot(3);
    tick();
    enable = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin tick(); if ({an, seg, dp} == DARK) dcnt++; end
    chk("enable_dark", dcnt, 10);
    enable = 1'b1;
    n = 0;
    tick();
    while (an == 6'h37 && n < 10) begin n++; tick(); end
    chk("resume_slot3", n, 2);
    chk("resume_next", an, 6'h2F);
    for (int k = 0; k < 5; k++) tick();
    do_reset();
    for (int k = 0; k < 30; k++) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
